// File: rtl/yarp_fetch.sv
// yarp RV32I instruction fetch: owns the PC, issues one outstanding imem read,
// and buffers the returned word for decode with an opcode legality pre-check.
module yarp_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_illegal_o,
    input  logic        instr_ready_i
);

    typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_pc, req_pc_nxt;
    logic        discard, discard_nxt;
    logic        valid_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] ipc_nxt;
    logic        ill_nxt;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};

    function automatic logic is_illegal(input logic [31:0] w);
        case (w[6:0])
            7'h33, 7'h03, 7'h13, 7'h67, 7'h37,
            7'h17, 7'h23, 7'h63, 7'h6F: return 1'b0;
            default:                    return 1'b1;
        endcase
    endfunction

    // Request side is combinational from state/pc, forced low while in reset.
    assign imem_req_o  = !reset && (state == ST_REQ);
    assign imem_addr_o = reset ? 32'h0 : pc;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        req_pc_nxt  = req_pc;
        discard_nxt = discard;
        valid_nxt   = instr_valid_o;
        instr_nxt   = instr_o;
        ipc_nxt     = instr_pc_o;
        ill_nxt     = instr_illegal_o;

        case (state)
            ST_REQ: begin
                if (imem_gnt_i) begin
                    req_pc_nxt  = pc;
                    state_nxt   = ST_WAIT;
                    // a redirect alongside the grant makes the in-flight word stale
                    discard_nxt = redirect_i;
                end
                if (redirect_i) pc_nxt = redirect_tgt;
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    pc_nxt = redirect_tgt;
                    if (imem_rvalid_i) begin
                        discard_nxt = 1'b0;
                        state_nxt   = ST_REQ;
                    end else begin
                        discard_nxt = 1'b1;
                    end
                end else if (imem_rvalid_i) begin
                    if (discard) begin
                        discard_nxt = 1'b0;
                        state_nxt   = ST_REQ;
                    end else begin
                        valid_nxt = 1'b1;
                        instr_nxt = imem_rdata_i;
                        ipc_nxt   = req_pc;
                        ill_nxt   = is_illegal(imem_rdata_i);
                        pc_nxt    = req_pc + 32'd4;
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_i || (instr_valid_o && instr_ready_i)) begin
                    valid_nxt = 1'b0;
                    state_nxt = ST_REQ;
                    if (redirect_i) pc_nxt = redirect_tgt;
                end
            end
            default: state_nxt = ST_REQ;
        endcase

        if (redirect_i) valid_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_REQ;
            pc              <= RESET_PC;
            req_pc          <= 32'h0;
            discard         <= 1'b0;
            instr_valid_o   <= 1'b0;
            instr_o         <= 32'h0;
            instr_pc_o      <= 32'h0;
            instr_illegal_o <= 1'b0;
        end else begin
            state           <= state_nxt;
            pc              <= pc_nxt;
            req_pc          <= req_pc_nxt;
            discard         <= discard_nxt;
            instr_valid_o   <= valid_nxt;
            instr_o         <= instr_nxt;
            instr_pc_o      <= ipc_nxt;
            instr_illegal_o <= ill_nxt;
        end
    end

endmodule

// File: tb/tb_yarp_fetch.sv
// Bench for yarp_fetch: directed scenarios plus a randomized run checked
// against a PC-stream reference model and an address-hashed instruction memory.
module tb_yarp_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_illegal_o;
    logic        instr_ready_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    yarp_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_illegal_o(instr_illegal_o), .instr_ready_i(instr_ready_i)
    );

    logic [6:0] legal_ops [9] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h37, 7'h17, 7'h23, 7'h63, 7'h6F};

    function automatic logic ref_illegal(input logic [31:0] w);
        for (int i = 0; i < 9; i++)
            if (w[6:0] == legal_ops[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Memory contents: a hash of the address, biased toward legal opcodes.
    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] h;
        h = (a ^ 32'hA5A5_1234) * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        if (h[3:0] < 4'd9) return {h[31:7], legal_ops[h[3:0]]};
        return h;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b0;
    endtask

    task automatic fetch_one(input logic [31:0] data);
        int n = 0;
        while (!imem_req_o && n < 20) begin
            tick();
            n++;
        end
        if (!imem_req_o) begin
            checks++; failures++;
            $display("FAIL fetch_req_timeout: req=%0b required=1", imem_req_o);
        end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data;
        tick();
        imem_rvalid_i = 1'b0;
    endtask

    task automatic handshake;
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req: got %0b want 0", imem_req_o); end
        checks++; if (imem_addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h want 0", imem_addr_o); end
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b want 0", instr_valid_o); end
        checks++; if (instr_o !== 32'h0 || instr_pc_o !== 32'h0 || instr_illegal_o !== 1'b0) begin
            failures++; $display("FAIL rst_buf: instr=%h pc=%h ill=%0b want all 0", instr_o, instr_pc_o, instr_illegal_o);
        end
        reset = 1'b0;
        #1;
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            failures++; $display("FAIL first_req: req=%0b addr=%h want 1/0", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_basic;
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL wait_req: got %0b want 0", imem_req_o); end
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0050_0093;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h0050_0093 || instr_pc_o !== 32'h0 || instr_illegal_o !== 1'b0) begin
            failures++; $display("FAIL basic_deliver: v=%0b i=%h pc=%h ill=%0b want 1/00500093/0/0",
                                 instr_valid_o, instr_o, instr_pc_o, instr_illegal_o);
        end
    endtask

    task automatic test_stall;
        instr_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h0050_0093 || instr_pc_o !== 32'h0 || imem_req_o !== 1'b0) begin
                failures++; $display("FAIL stall_hold[%0d]: v=%0b i=%h pc=%h req=%0b", i, instr_valid_o, instr_o, instr_pc_o, imem_req_o);
            end
        end
        handshake();
        checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
            failures++; $display("FAIL stall_next: v=%0b req=%0b addr=%h want 0/1/4", instr_valid_o, imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_redirect_wait;
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        tick();
        redirect_i = 1'b0;
        checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
            failures++; $display("FAIL rdw_wait: v=%0b req=%0b want 0/0", instr_valid_o, imem_req_o);
        end
        tick();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h1234_5678;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
            failures++; $display("FAIL rdw_drop: v=%0b req=%0b addr=%h want 0/1/100", instr_valid_o, imem_req_o, imem_addr_o);
        end
        fetch_one(32'h0000_0013);
        checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h100 || instr_o !== 32'h13) begin
            failures++; $display("FAIL rdw_deliver: v=%0b pc=%h i=%h want 1/100/13", instr_valid_o, instr_pc_o, instr_o);
        end
        handshake();
    endtask

    task automatic test_redirect_gnt;
        imem_gnt_i    = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        tick();
        imem_gnt_i = 1'b0;
        redirect_i = 1'b0;
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rdg_wait: req=%0b want 0", imem_req_o); end
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0000_0033;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
            failures++; $display("FAIL rdg_drop: v=%0b req=%0b addr=%h want 0/1/200", instr_valid_o, imem_req_o, imem_addr_o);
        end
        fetch_one(32'h0000_0037);
        checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h200 || instr_o !== 32'h37) begin
            failures++; $display("FAIL rdg_deliver: v=%0b pc=%h i=%h want 1/200/37", instr_valid_o, instr_pc_o, instr_o);
        end
        handshake();
    endtask

    task automatic test_illegal;
        logic [31:0] words [3] = '{32'h0000_007F, 32'h0000_006F, 32'h0000_0000};
        logic        want  [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            fetch_one(words[i]);
            checks++; if (instr_valid_o !== 1'b1 || instr_illegal_o !== want[i] || instr_pc_o !== 32'h204 + 32'(4 * i)) begin
                failures++; $display("FAIL illegal[%0d]: v=%0b ill=%0b pc=%h want 1/%0b/%h",
                                     i, instr_valid_o, instr_illegal_o, instr_pc_o, want[i], 32'h204 + 32'(4 * i));
            end
            handshake();
        end
    endtask

    task automatic test_wrap;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_addr: req=%0b addr=%h want 1/fffffffc", imem_req_o, imem_addr_o);
        end
        fetch_one(32'h0000_0013);
        checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_pc: v=%0b pc=%h want 1/fffffffc", instr_valid_o, instr_pc_o);
        end
        handshake();
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            failures++; $display("FAIL wrap_next: req=%0b addr=%h want 1/0", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_reset_mid;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0400;
        tick();
        redirect_i = 1'b0;
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        reset      = 1'b1;
        tick();
        checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || imem_addr_o !== 32'h0) begin
            failures++; $display("FAIL midrst_out: req=%0b v=%0b addr=%h want 0/0/0", imem_req_o, instr_valid_o, imem_addr_o);
        end
        reset         = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0000_0013;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            failures++; $display("FAIL midrst_ignore: v=%0b req=%0b addr=%h want 0/1/0", instr_valid_o, imem_req_o, imem_addr_o);
        end
    endtask

    // Reference: the delivered PC stream starts at RESET_PC, advances by 4 on
    // each accepted instruction, and jumps to the aligned target on a redirect.
    task automatic test_random;
        logic [31:0] exp_pc = 32'h0;
        logic        pending = 1'b0;
        logic [31:0] paddr = 32'h0;
        int          cnt = 0;
        logic        prev_valid = 1'b0, prev_drop = 1'b0, prev_ill = 1'b0;
        logic [31:0] prev_instr = 32'h0, prev_pc = 32'h0, tgt;
        int          deliveries = 0;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (instr_valid_o && !prev_valid) begin
                deliveries++;
                checks++; if (instr_pc_o !== exp_pc) begin
                    failures++; $display("FAIL rnd_pc@%0d: got %h want %h", cyc, instr_pc_o, exp_pc);
                end
                checks++; if (instr_o !== memword(instr_pc_o)) begin
                    failures++; $display("FAIL rnd_instr@%0d: got %h want %h", cyc, instr_o, memword(instr_pc_o));
                end
                checks++; if (instr_illegal_o !== ref_illegal(instr_o)) begin
                    failures++; $display("FAIL rnd_ill@%0d: got %0b want %0b", cyc, instr_illegal_o, ref_illegal(instr_o));
                end
            end
            if (instr_valid_o && prev_valid) begin
                checks++; if (instr_o !== prev_instr || instr_pc_o !== prev_pc || instr_illegal_o !== prev_ill) begin
                    failures++; $display("FAIL rnd_stable@%0d: i=%h pc=%h was %h/%h", cyc, instr_o, instr_pc_o, prev_instr, prev_pc);
                end
            end
            if (prev_drop) begin
                checks++; if (instr_valid_o !== 1'b0) begin
                    failures++; $display("FAIL rnd_flush@%0d: valid=%0b want 0", cyc, instr_valid_o);
                end
            end
            checks++; if (imem_req_o && instr_valid_o) begin
                failures++; $display("FAIL rnd_req_while_valid@%0d: req=1 valid=1 want not both", cyc);
            end

            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
            if (pending) begin
                if (cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = memword(paddr);
                    pending       = 1'b0;
                end else begin
                    cnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                imem_rvalid_i = 1'b1;
            end
            imem_gnt_i    = imem_req_o && ($urandom_range(0, 2) != 0);
            instr_ready_i = $urandom_range(0, 1) == 1;
            redirect_i    = $urandom_range(0, 11) == 0;
            tgt           = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
            redirect_pc_i = tgt;
            if (imem_gnt_i) begin
                checks++; if (imem_addr_o !== exp_pc) begin
                    failures++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, imem_addr_o, exp_pc);
                end
                pending = 1'b1;
                paddr   = imem_addr_o;
                cnt     = $urandom_range(0, 2);
            end

            prev_drop  = redirect_i || (instr_valid_o && instr_ready_i);
            prev_valid = instr_valid_o;
            prev_instr = instr_o;
            prev_pc    = instr_pc_o;
            prev_ill   = instr_illegal_o;
            if (redirect_i) exp_pc = {tgt[31:2], 2'b00};
            else if (instr_valid_o && instr_ready_i) exp_pc = exp_pc + 32'd4;
            tick();
        end
        idle_inputs();
        checks++; if (deliveries < 20) begin
            failures++; $display("FAIL rnd_deliveries: got %0d want >=20", deliveries);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_gnt();
        test_illegal();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
